// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline controller: exception codes,
// stall-vector encodings and the divider sequencer state type.
package pipe_pkg;

  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL    = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES    = 32'h0000_0005;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_BREAK   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI      = 32'h0000_000A;
  localparam logic [31:0] EXC_OV      = 32'h0000_000C;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000E;

  // Bit i set means pipeline register i holds; [0]PC .. [5]WB.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_START = 2'd1,
    D_BUSY  = 2'd2,
    D_DONE  = 2'd3
  } div_state_t;

  // ERET returns to EPC; every other nonzero code, known or not, takes the vector.
  function automatic logic [31:0] flush_target(input logic [31:0] code,
                                               input logic [31:0] epc,
                                               input logic [31:0] vec);
    logic [31:0] tgt;
    if (code == EXC_ERET) begin
      tgt = epc;
    end else begin
      tgt = vec;
    end
    return tgt;
  endfunction

endpackage

// File: rtl/pipe_div_seq.sv
// Divider handshake sequencer: start/busy/done with flush abort and
// result hold while the EX/MEM register is stalled.
module pipe_div_seq
  import pipe_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic div_start_i,
  input  logic div_ready_i,
  input  logic flush_i,
  input  logic ex_stall_i,
  output logic go_o,
  output logic cancel_o,
  output logic done_o,
  output logic busy_o
);

  div_state_t state_q, state_d;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= D_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Kept apart from the next-state block so the stall path has no comb loop.
  assign busy_o = (state_q == D_START) || (state_q == D_BUSY);

  // Next-state and handshake outputs; a flush always beats a ready divider.
  always_comb begin
    state_d  = state_q;
    go_o     = 1'b0;
    cancel_o = 1'b0;
    done_o   = 1'b0;
    case (state_q)
      D_IDLE: begin
        if (div_start_i && !flush_i) begin
          state_d = D_START;
        end else begin
          state_d = D_IDLE;
        end
      end
      D_START: begin
        if (flush_i) begin
          cancel_o = 1'b1;
          state_d  = D_IDLE;
        end else begin
          go_o    = 1'b1;
          state_d = D_BUSY;
        end
      end
      D_BUSY: begin
        if (flush_i) begin
          cancel_o = 1'b1;
          state_d  = D_IDLE;
        end else if (div_ready_i) begin
          go_o    = 1'b1;
          state_d = D_DONE;
        end else begin
          go_o    = 1'b1;
          state_d = D_BUSY;
        end
      end
      D_DONE: begin
        if (flush_i) begin
          cancel_o = 1'b1;
          state_d  = D_IDLE;
        end else if (ex_stall_i) begin
          done_o  = 1'b1;
          state_d = D_DONE;
        end else begin
          done_o  = 1'b1;
          state_d = D_IDLE;
        end
      end
      default: begin
        state_d = D_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall merge, timed exception/ERET flush with
// redirect PC, and divider sequencing for the 5-stage MIPS core.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_exe_i,
  input  logic        stallreq_mem_i,
  input  logic        div_start_i,
  input  logic        div_ready_i,
  input  logic [31:0] exception_type_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        div_go_o,
  output logic        div_cancel_o,
  output logic        div_done_o
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic        exc_take_s;
  logic        flush_s;
  logic [31:0] target_s;
  logic [31:0] new_pc_s;
  logic [5:0]  stall_s;
  logic        div_busy_s;
  logic        div_go_s;
  logic        div_cancel_s;
  logic        div_done_s;

  // Codes arriving while the counter runs belong to squashed instructions.
  assign exc_take_s = (exception_type_i != 32'h0) && (cnt_q == 3'd0);
  assign flush_s    = exc_take_s || (cnt_q != 3'd0);
  assign target_s   = flush_target(exception_type_i, cp0_epc_i, EXC_VECTOR);

  // Flush counter and latched redirect target, next-state.
  always_comb begin
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    new_pc_s = 32'h0;
    if (exc_take_s) begin
      cnt_d    = FLUSH_LOAD;
      pc_d     = target_s;
      new_pc_s = target_s;
    end else if (cnt_q != 3'd0) begin
      cnt_d    = cnt_q - 3'd1;
      new_pc_s = pc_q;
    end else begin
      cnt_d    = 3'd0;
      new_pc_s = 32'h0;
    end
  end

  // Flush counter and redirect target registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 3'd0;
      pc_q  <= 32'h0;
    end else begin
      cnt_q <= cnt_d;
      pc_q  <= pc_d;
    end
  end

  // Stall merge; the deepest stalled stage wins, flush overrides everything.
  always_comb begin
    stall_s = STALL_NONE;
    if (flush_s) begin
      stall_s = STALL_NONE;
    end else if (stallreq_mem_i) begin
      stall_s = STALL_MEM;
    end else if (stallreq_exe_i || div_busy_s) begin
      stall_s = STALL_EX;
    end else if (stallreq_id_i) begin
      stall_s = STALL_ID;
    end else if (stallreq_if_i) begin
      stall_s = STALL_IF;
    end else begin
      stall_s = STALL_NONE;
    end
  end

  pipe_div_seq u_div_seq (
    .clk         (clk),
    .rst         (rst),
    .div_start_i (div_start_i),
    .div_ready_i (div_ready_i),
    .flush_i     (flush_s),
    .ex_stall_i  (stall_s[3]),
    .go_o        (div_go_s),
    .cancel_o    (div_cancel_s),
    .done_o      (div_done_s),
    .busy_o      (div_busy_s)
  );

  // Hold every output at its reset value while rst is low.
  assign stall_o      = rst ? stall_s      : 6'b000000;
  assign flush_o      = rst ? flush_s      : 1'b0;
  assign new_pc_o     = rst ? new_pc_s     : 32'h0;
  assign div_go_o     = rst ? div_go_s     : 1'b0;
  assign div_cancel_o = rst ? div_cancel_s : 1'b0;
  assign div_done_o   = rst ? div_done_s   : 1'b0;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS core.
- Merges per-stage stall requests into the per-register stall vector that drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Sequences the multi-cycle divider through a start/busy/done handshake.
- Turns MEM-stage exceptions and ERET into a timed flush plus a redirect PC.

Parameters:
- EXC_VECTOR, 32'hBFC00380, general exception entry address.
- FLUSH_CYCLES, 1, number of cycles flush_o stays high per event (1..7).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock, synchronous and active-low (rst==0 resets on posedge clk).
- stallreq_if_i  in  1  fetch not ready (icache/bus miss).
- stallreq_id_i  in  1  load-use hazard in ID.
- stallreq_exe_i  in  1  non-divider multi-cycle op in EX.
- stallreq_mem_i  in  1  data access not ready.
- div_start_i  in  1  EX holds a DIV/DIVU needing the divider.
- div_ready_i  in  1  divider result valid.
- exception_type_i  in  32  MEM-stage exception code; 0 means none.
- cp0_epc_i  in  32  current EPC, used for ERET.
- stall_o  out  6  [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB.
- flush_o  out  1  clear all pipeline registers.
- new_pc_o  out  32  redirect target; valid while flush_o==1.
- div_go_o  out  1  divider run enable.
- div_cancel_o  out  1  one-cycle divider abort.
- div_done_o  out  1  one-cycle pulse: EX captures the quotient/remainder.

Behaviour:
- Reset (rst==0): stall_o=0, flush_o=0, new_pc_o=0, div_go_o=0, div_cancel_o=0, div_done_o=0, divider FSM=D_IDLE, flush counter=0.
- Stall vector, combinational; highest active source wins:
  - flush_o=1: 6'b000000.
  - stallreq_mem_i: 6'b011111.
  - stallreq_exe_i, or divider FSM in D_START/D_BUSY: 6'b001111.
  - stallreq_id_i: 6'b000111.
  - stallreq_if_i: 6'b000011.
  - otherwise 0.
- Exception/flush:
  - In a cycle N with exception_type_i!=0 and flush counter==0, flush_o=1 combinationally in cycle N (zero latency).
  - new_pc_o = cp0_epc_i if code==EXC_ERET, else EXC_VECTOR.
  - The target is also latched. The counter loads FLUSH_CYCLES-1, and flush_o plus the latched new_pc_o hold until the counter reaches 0, decrementing each cycle.
  - While the counter is nonzero, exception_type_i is ignored (it comes from squashed instructions).
  - Back-to-back exceptions are accepted only once the counter reaches 0.
- Divider FSM (states D_IDLE, D_START, D_BUSY, D_DONE):
  - D_IDLE: div_start_i && !flush_o -> D_START.
  - D_START: div_go_o=1 for one cycle -> D_BUSY.
  - D_BUSY: div_go_o=1; div_ready_i -> D_DONE.
  - D_DONE: div_done_o=1 for one cycle, stall released this cycle, div_go_o=0 -> D_IDLE. div_start_i is ignored in D_DONE, which prevents the same DIV restarting.
- Divider flush and stall interaction:
  - flush_o=1 in D_START/D_BUSY/D_DONE -> D_IDLE next cycle, div_cancel_o=1 that cycle, no div_done_o.
  - div_ready_i in the same cycle as flush_o: flush wins.
  - stallreq_mem_i while D_BUSY: FSM keeps counting; on D_DONE with the MEM stall still active, the FSM stays in D_DONE with div_done_o held until stall_o[3]==0, so EX captures the result exactly once.
- Reset mid-division or mid-flush: returns to the reset state next edge, no cancel pulse.
- Exception codes are compared on the full 32-bit value; unknown nonzero codes vector to EXC_VECTOR.

Decomposition:
- Package pipe_pkg holds:
  - exception codes: EXC_INT=32'h1, EXC_ADEL=32'h4, EXC_ADES=32'h5, EXC_SYSCALL=32'h8, EXC_BREAK=32'h9, EXC_RI=32'hA, EXC_OV=32'hC, EXC_ERET=32'hE;
  - stall vector constants STALL_IF, STALL_ID, STALL_EX, STALL_MEM;
  - the div_state_t enum.
- One sub-module: pipe_div_seq, holding the divider FSM with inputs div_start/div_ready/flush/ex_stall and outputs go/cancel/done/busy.

Test Plan:
- Priority: release reset; assert stallreq_id_i and stallreq_mem_i together -> stall_o=6'b011111; drop mem -> 6'b000111.
- Syscall: exception_type_i=32'h8 for 1 cycle -> same cycle flush_o=1, new_pc_o=32'hBFC00380, stall_o=0; next cycle flush_o=0.
- ERET with FLUSH_CYCLES=3: cp0_epc_i=32'h8000_1234, code 32'hE -> flush_o high 3 cycles, new_pc_o=32'h80001234 throughout; a second code 32'hC on cycle 2 is ignored.
- Division: div_start_i=1 -> D_START with stall_o=6'b001111; div_ready_i 20 cycles later -> div_done_o one pulse, stall_o=0 the cycle after.
- Abort: exception during D_BUSY, with div_ready_i asserted the same cycle -> flush_o=1, div_cancel_o=1, div_done_o never pulses, FSM in D_IDLE next cycle.
- Reset: rst=0 mid-D_BUSY with stallreq_exe_i=1 -> next edge all outputs 0; rst high again -> no stale div_go_o.
